// File: rtl/fifo_ram_ctrl_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types, depth constant and pointer helper for the
//               fifo_ram_ctrl block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned DEPTH          = 2 ** ADDR_WIDTH_DEF;

    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;
    typedef logic [ADDR_WIDTH_DEF:0] cnt_t;

    // Wrap-around increment for a pointer of ptr_width bits (MSB is the wrap bit)
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned ptr_width);
        logic [31:0] mask;
        mask = (ptr_width >= 32) ? '1 : ((32'd1 << ptr_width) - 32'd1);
        return (ptr + 32'd1) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram_ctrl_if.sv
// ============================================================================
// Module      : fifo_ram_ctrl_if
// Description : Push/pop handshake, status flags and dual-port RAM bus of the
//               FIFO controller. Optional FIFO_ERR_FLAGS_EN adds error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_ram_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic                  ram_wr_ce;
    logic                  ram_wr_we;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic                  ram_rd_ce;
    logic                  ram_rd_we;
    logic [DATA_WIDTH-1:0] ram_rd_data;
`ifdef FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport slave (
        input  wr_en, wr_data, rd_en, ram_rd_data,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
        output ram_wr_addr, ram_wr_ce, ram_wr_we, ram_wr_data,
        output ram_rd_addr, ram_rd_ce, ram_rd_we
`ifdef FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );

    modport master (
        output wr_en, wr_data, rd_en, ram_rd_data,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
        input  ram_wr_addr, ram_wr_ce, ram_wr_we, ram_wr_data,
        input  ram_rd_addr, ram_rd_ce, ram_rd_we
`ifdef FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );

endinterface

`default_nettype wire

// File: rtl/fifo_ram_ctrl_flag_gen.sv
// ============================================================================
// Module      : fifo_flag_gen
// Description : Combinational full/empty/almost flags and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_flag_gen #(
    parameter int ADDR_WIDTH      = 8,
    parameter int ALMOST_FULL_TH  = (2 ** ADDR_WIDTH) - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  wire logic [ADDR_WIDTH:0] i_wr_ptr,
    input  wire logic [ADDR_WIDTH:0] i_wr_ptr_c,
    input  wire logic [ADDR_WIDTH:0] i_rd_ptr,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic [ADDR_WIDTH:0]      o_count
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0] w_count;

    assign w_count = i_wr_ptr - i_rd_ptr;

    // Full uses the speculative write pointer so no push can overrun an entry
    // still waiting to be popped; empty uses the committed pointer so a pop
    // never reads an address whose RAM write is still in flight.
    assign o_full         = (i_wr_ptr[ADDR_WIDTH] != i_rd_ptr[ADDR_WIDTH]) &&
                            (i_wr_ptr[ADDR_WIDTH-1:0] == i_rd_ptr[ADDR_WIDTH-1:0]);
    assign o_empty        = (i_wr_ptr_c == i_rd_ptr);
    assign o_almost_full  = (w_count >= CNT_W'(ALMOST_FULL_TH));
    assign o_almost_empty = (w_count <= CNT_W'(ALMOST_EMPTY_TH));
    assign o_count        = w_count;

endmodule

`default_nettype wire

// File: rtl/fifo_ram_ctrl.sv
// ============================================================================
// Module      : fifo_ram_ctrl
// Description : Synchronous FIFO controller driving an external dual-port RAM
//               through a registered write stage. Optional FIFO_ERR_FLAGS_EN
//               adds sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int ALMOST_FULL_TH  = (2 ** ADDR_WIDTH) - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fifo_ram_ctrl_if.slave   bus
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_wr_ptr_c;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_ram_wr_addr;
    logic [DATA_WIDTH-1:0] r_ram_wr_data;
    logic                  r_ram_wr_ce;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    fifo_flag_gen #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .ALMOST_FULL_TH  (ALMOST_FULL_TH),
        .ALMOST_EMPTY_TH (ALMOST_EMPTY_TH)
    ) u_flag_gen (
        .i_wr_ptr       (r_wr_ptr),
        .i_wr_ptr_c     (r_wr_ptr_c),
        .i_rd_ptr       (r_rd_ptr),
        .o_full         (w_full),
        .o_empty        (w_empty),
        .o_almost_full  (bus.almost_full),
        .o_almost_empty (bus.almost_empty),
        .o_count        (bus.count)
    );

    assign w_push_ok = bus.wr_en && !w_full;
    assign w_pop_ok  = bus.rd_en && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_wr_ptr_c    <= '0;
            r_ram_wr_addr <= '0;
            r_ram_wr_data <= '0;
            r_ram_wr_ce   <= 1'b0;
        end else begin
            // Committed pointer trails by one cycle, matching the RAM write stage
            r_wr_ptr_c  <= r_wr_ptr;
            r_ram_wr_ce <= w_push_ok;
            if (w_push_ok) begin
                r_ram_wr_addr <= r_wr_ptr[ADDR_WIDTH-1:0];
                r_ram_wr_data <= bus.wr_data;
                r_wr_ptr      <= PTR_W'(ptr_inc(32'(r_wr_ptr), PTR_W));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_rd_data <= bus.ram_rd_data;
                r_rd_ptr  <= PTR_W'(ptr_inc(32'(r_rd_ptr), PTR_W));
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif

    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.ram_wr_addr = r_ram_wr_addr;
    assign bus.ram_wr_data = r_ram_wr_data;
    assign bus.ram_wr_ce   = r_ram_wr_ce;
    assign bus.ram_wr_we   = 1'b1;
    assign bus.ram_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];
    assign bus.ram_rd_ce   = !rst;
    assign bus.ram_rd_we   = 1'b0;

endmodule

`default_nettype wire

// File: doc/fifo_ram_ctrl.md
Name: fifo_ram_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream of the team's dual-port RAM and drives both of its ports.
- Accepts push/pop handshakes and manages wrap-around read/write pointers.
- Generates full/empty/almost flags and an occupancy count.
- Registers RAM writes into a one-cycle write stage, so RAM address/data/enable are stable for a whole cycle.
- Captures popped data into an output register.

Parameters:
DATA_WIDTH, 8, width of each FIFO entry and of the RAM data ports
ADDR_WIDTH, 8, RAM address width; DEPTH = 2**ADDR_WIDTH entries
ALMOST_FULL_TH, DEPTH-2, almost_full asserts when count >= this value
ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this value

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  push request
wr_data  in  DATA_WIDTH  push data
rd_en  in  1  pop request
rd_data  out  DATA_WIDTH  registered popped data
rd_valid  out  1  one-cycle pulse: rd_data holds a newly popped entry
full  out  1  no push accepted this cycle
empty  out  1  no committed entry available for pop
almost_full  out  1  count >= ALMOST_FULL_TH
almost_empty  out  1  count <= ALMOST_EMPTY_TH
count  out  ADDR_WIDTH+1  accepted pushes minus accepted pops, 0..DEPTH
ram_wr_addr  out  ADDR_WIDTH  RAM port 0 address
ram_wr_ce  out  1  RAM port 0 chip enable
ram_wr_we  out  1  RAM port 0 write/read select; tied 1
ram_wr_data  out  DATA_WIDTH  RAM port 0 data
ram_rd_addr  out  ADDR_WIDTH  RAM port 1 address; equals rd_ptr low bits
ram_rd_ce  out  1  RAM port 1 chip enable; 1 except during reset
ram_rd_we  out  1  RAM port 1 write/read select; tied 0
ram_rd_data  in  DATA_WIDTH  RAM port 1 read data (combinational from ram_rd_addr)

Behaviour:
- Reset (rst=1 at an edge) clears the following; reset overrides any push or pop in the same cycle. RAM contents are not cleared.
  - wr_ptr, wr_ptr_c, rd_ptr = 0
  - ram_wr_ce, rd_valid = 0; rd_data = 0
  - After reset: empty=1, almost_empty=1, full=0, almost_full=0, count=0
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit. Increment modulo 2**(ADDR_WIDTH+1).
- push_ok = wr_en & !full.
  - On push_ok: latch ram_wr_addr <= wr_ptr[ADDR_WIDTH-1:0] and ram_wr_data <= wr_data.
  - ram_wr_ce <= 1 for exactly the next cycle; wr_ptr increments.
- wr_ptr_c (committed pointer) <= wr_ptr every cycle, so it lags wr_ptr by one cycle. The entry is in RAM by then.
- pop_ok = rd_en & !empty.
  - On pop_ok: rd_data <= ram_rd_data, rd_valid <= 1, rd_ptr increments.
  - Otherwise rd_valid <= 0 and rd_data holds its value.
- Flags, all combinational from registers:
  - full = (wr_ptr[MSB] != rd_ptr[MSB]) & (low bits equal)
  - empty = (wr_ptr_c == rd_ptr)
  - count = wr_ptr - rd_ptr
- Latencies:
  - push edge to empty deassert: 2 edges.
  - pop edge to rd_valid: same edge (rd_valid visible in the following cycle).
  - pop to full deassert: 1 edge.
- Simultaneous push and pop:
  - Both are accepted when neither is blocked; count is unchanged.
  - When full, only the pop is accepted.
  - When empty, only the push is accepted.
  - A pop is never served from the in-flight write stage.
- Push while full and pop while empty are ignored; no state changes.
- Wrap-around: after DEPTH pushes and pops, pointer low bits return to 0 and the MSB toggles. Flags stay correct.

Optional Feature:
FIFO_ERR_FLAGS_EN
- With the macro: adds outputs overflow and underflow (1 bit each), sticky, cleared only by rst.
  - overflow sets on wr_en & full.
  - underflow sets on rd_en & empty.
- Without the macro: those ports do not exist; rejected requests are silently dropped.

Decomposition:
- Shared package fifo_pkg holds:
  - pointer typedef ptr_t (ADDR_WIDTH+1 bits)
  - count typedef cnt_t
  - localparam DEPTH
  - function ptr_inc
- One natural sub-module, fifo_flag_gen: combinational full/empty/almost/count from wr_ptr, wr_ptr_c, rd_ptr and the thresholds.
- The RAM is instantiated by the parent, not by this block.

Test Plan:
1. Reset with ADDR_WIDTH=2 (DEPTH=4) -> empty=1, full=0, count=0, rd_valid=0, ram_wr_ce=0.
2. Push 0xA5 at edge N -> ram_wr_ce=1 with addr 0 in cycle N+1, empty=0 after edge N+1. Then pop -> rd_data=0xA5, rd_valid=1 for one cycle, empty=1.
3. Push 0x01..0x04 (DEPTH=4) -> full=1, count=4. Push 0x05 -> ignored, count=4. Pop four times -> 0x01..0x04 in order.
4. Full FIFO, simultaneous push 0x10 and pop -> pop accepted, push rejected, count=3, full=0.
5. Wrap-around: 10 interleaved push/pop pairs of 0x20..0x29 (DEPTH=4) -> data out in order; count toggles 1/0; no false full.
6. rst asserted with count=3 and a pending write stage -> next cycle empty=1, count=0, ram_wr_ce=0. With FIFO_ERR_FLAGS_EN, underflow=0 until a pop on empty, then it stays 1.
